// File: rtl/writeback_stage_if.sv
// Writeback-stage bus bundle.
// Groups every M->W pipeline input and every W-stage output of writeback_stage
// so the stage can be wired with a single port. Clock and reset stay outside.
//   slave  : seen by writeback_stage (consumes M inputs and stall/flush,
//            drives W outputs)
//   master : seen by whoever drives the stage (pipeline control / testbench)
// Signals:
//   StallW, FlushW               hazard control for the W register
//   ValidM, RegWriteM, MemtoRegM, PCSrcM, ByteM, ALUOutM, ReadDataM, WA3M
//                                M-stage instruction fields
//   ValidW, RegWriteW, PCSrcW, WA3W, ResultW, RetireCount
//                                W-stage outputs
interface writeback_stage_if #(
  parameter int CNT_W = 32
);
  logic             StallW;
  logic             FlushW;
  logic             ValidM;
  logic             RegWriteM;
  logic             MemtoRegM;
  logic             PCSrcM;
  logic             ByteM;
  logic [31:0]      ALUOutM;
  logic [31:0]      ReadDataM;
  logic [3:0]       WA3M;
  logic             ValidW;
  logic             RegWriteW;
  logic             PCSrcW;
  logic [3:0]       WA3W;
  logic [31:0]      ResultW;
  logic [CNT_W-1:0] RetireCount;

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, MemtoRegM, PCSrcM, ByteM,
           ALUOutM, ReadDataM, WA3M,
    output ValidW, RegWriteW, PCSrcW, WA3W, ResultW, RetireCount
  );

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, MemtoRegM, PCSrcM, ByteM,
           ALUOutM, ReadDataM, WA3M,
    input  ValidW, RegWriteW, PCSrcW, WA3W, ResultW, RetireCount
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback pipeline stage.
// Holds the M->W pipeline register, selects the register-file write data
// (ALU result, loaded word, or zero-extended loaded byte) and counts retired
// instructions.
// Ports:
//   CLK    rising-edge clock for all state
//   RESET  asynchronous, active-low reset
//   wb     writeback_stage_if.slave bundle (M inputs, stall/flush, W outputs)
// Parameter:
//   CNT_W  width of the retired-instruction counter (wraps at all-ones)
module writeback_stage #(
  parameter int CNT_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  writeback_stage_if.slave  wb
);

  logic             r_valid;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic             r_pcsrc;
  logic             r_byte;
  logic [31:0]      r_aluout;
  logic [31:0]      r_readdata;
  logic [3:0]       r_wa3;
  logic [CNT_W-1:0] r_retire_cnt;

  logic [7:0]       w_byte_sel;
  logic [31:0]      w_result;
  logic             w_retire;

  // An instruction retires on the edge it leaves W: valid, not held, not killed.
  assign w_retire = r_valid & ~wb.StallW & ~wb.FlushW;

  // Control bits: flush wins over stall.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_pcsrc    <= 1'b0;
      r_byte     <= 1'b0;
    end else if (wb.FlushW) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_pcsrc    <= 1'b0;
      r_byte     <= 1'b0;
    end else if (!wb.StallW) begin
      r_valid    <= wb.ValidM;
      r_regwrite <= wb.RegWriteM;
      r_memtoreg <= wb.MemtoRegM;
      r_pcsrc    <= wb.PCSrcM;
      r_byte     <= wb.ByteM;
    end
  end

  // Data fields are left untouched by a flush; the cleared valid bit
  // already makes them harmless.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_aluout   <= '0;
      r_readdata <= '0;
      r_wa3      <= '0;
    end else if (!wb.FlushW && !wb.StallW) begin
      r_aluout   <= wb.ALUOutM;
      r_readdata <= wb.ReadDataM;
      r_wa3      <= wb.WA3M;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  // Little-endian byte lane selected by the low address bits.
  always_comb begin
    w_byte_sel = r_readdata[7:0];
    case (r_aluout[1:0])
      2'b00: w_byte_sel = r_readdata[7:0];
      2'b01: w_byte_sel = r_readdata[15:8];
      2'b10: w_byte_sel = r_readdata[23:16];
      2'b11: w_byte_sel = r_readdata[31:24];
      default: w_byte_sel = r_readdata[7:0];
    endcase
  end

  always_comb begin
    w_result = r_aluout;
    if (r_memtoreg) begin
      if (r_byte) w_result = {24'h0, w_byte_sel};
      else        w_result = r_readdata;
    end
  end

  assign wb.ValidW      = r_valid;
  assign wb.RegWriteW   = r_regwrite & r_valid;
  assign wb.PCSrcW      = r_pcsrc & r_valid;
  assign wb.WA3W        = r_wa3;
  assign wb.ResultW     = w_result;
  assign wb.RetireCount = r_retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int CNT_W = 4;

  logic CLK;
  logic RESET;

  writeback_stage_if #(.CNT_W(CNT_W)) bus ();

  writeback_stage #(.CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .wb    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the instruction currently sitting in W plus a count.
  typedef struct {
    bit          valid, rw, m2r, pcs, byt;
    logic [31:0] alu, rd;
    logic [3:0]  wa3;
  } instr_t;

  instr_t mw;
  int unsigned m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_result(input instr_t w);
    if (!w.m2r)      return w.alu;
    else if (!w.byt) return w.rd;
    else             return (w.rd >> (8 * w.alu[1:0])) & 32'hFF;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(bus.ValidW),      32'(mw.valid));
    check({tag, ".rw"},    32'(bus.RegWriteW),   32'(mw.rw & mw.valid));
    check({tag, ".pcs"},   32'(bus.PCSrcW),      32'(mw.pcs & mw.valid));
    check({tag, ".wa3"},   32'(bus.WA3W),        32'(mw.wa3));
    check({tag, ".res"},   bus.ResultW,          exp_result(mw));
    check({tag, ".cnt"},   32'(bus.RetireCount), m_cnt % (1 << CNT_W));
  endtask

  task automatic model_reset();
    mw = '{default: '0};
    m_cnt = 0;
  endtask

  // One clock edge: model follows the same inputs, outputs checked 1ns later.
  task automatic step(input string tag);
    @(posedge CLK);
    if (mw.valid && !bus.StallW && !bus.FlushW) m_cnt++;
    if (bus.FlushW) begin
      mw.valid = 0; mw.rw = 0; mw.m2r = 0; mw.pcs = 0; mw.byt = 0;
    end else if (!bus.StallW) begin
      mw.valid = bus.ValidM;    mw.rw  = bus.RegWriteM;
      mw.m2r   = bus.MemtoRegM; mw.pcs = bus.PCSrcM;
      mw.byt   = bus.ByteM;     mw.alu = bus.ALUOutM;
      mw.rd    = bus.ReadDataM; mw.wa3 = bus.WA3M;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, rw, m2r, pcs, byt,
                       input logic [31:0] alu, rd, input logic [3:0] wa3);
    bus.ValidM = v; bus.RegWriteM = rw; bus.MemtoRegM = m2r;
    bus.PCSrcM = pcs; bus.ByteM = byt;
    bus.ALUOutM = alu; bus.ReadDataM = rd; bus.WA3M = wa3;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b1;
    bus.StallW = 0; bus.FlushW = 0;
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    #2;
    do_reset();

    // ALU path
    drive(1, 1, 0, 0, 0, 32'h7, 32'hDEAD_BEEF, 4'h2);
    step("alu");
    check("alu.result_const", bus.ResultW, 32'h0000_0007);
    check("alu.wa3_const", 32'(bus.WA3W), 32'h2);
    drive(0, 0, 0, 0, 0, '0, '0, '0);
    step("alu_retire");
    check("alu.cnt_const", 32'(bus.RetireCount), 32'h1);

    // Byte load, then word load
    drive(1, 1, 1, 0, 1, 32'h0000_1002, 32'hA1B2_C3D4, 4'h3);
    step("ldrb");
    check("ldrb.const", bus.ResultW, 32'h0000_00B2);
    drive(1, 1, 1, 0, 0, 32'h0000_1002, 32'hA1B2_C3D4, 4'h3);
    step("ldr");
    check("ldr.const", bus.ResultW, 32'hA1B2_C3D4);
    // Byte flag ignored without MemtoReg; same WA3 twice in a row
    drive(1, 1, 0, 0, 1, 32'h0000_1003, 32'hA1B2_C3D4, 4'h3);
    step("byte_ignored");
    check("byte_ignored.const", bus.ResultW, 32'h0000_1003);

    // Stall then flush
    drive(1, 1, 0, 0, 0, 32'h55, '0, 4'h5);
    step("stall_load");
    bus.StallW = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, $urandom, $urandom, 4'(i + 8));
      step("stall_hold");
      check("stall.wa3_const", 32'(bus.WA3W), 32'h5);
    end
    bus.FlushW = 1;
    step("flush_stall");
    check("flush.valid_const", 32'(bus.ValidW), 32'h0);
    bus.StallW = 0; bus.FlushW = 0;

    // PC write
    drive(1, 1, 0, 1, 0, 32'h0000_0100, '0, 4'hF);
    step("pcw");
    check("pcw.pcsrc_const", 32'(bus.PCSrcW), 32'h1);
    drive(0, 0, 0, 1, 0, '0, '0, 4'h0);
    step("pcw_off");
    check("pcw_off.pcsrc_const", 32'(bus.PCSrcW), 32'h0);

    // Counter wrap: 16 valid edges from reset give 15, one more wraps to 0
    @(negedge CLK);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, $urandom, '0, 4'(i));
      step("wrap_fill");
    end
    check("wrap.ones_const", 32'(bus.RetireCount), 32'hF);
    step("wrap");
    check("wrap.zero_const", 32'(bus.RetireCount), 32'h0);

    // Asynchronous reset between edges, asserted mid-stall
    bus.StallW = 1;
    @(negedge CLK);
    #2;
    do_reset();
    check("async.result_const", bus.ResultW, 32'h0);
    bus.StallW = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.StallW = ($urandom_range(0, 3) == 0);
      bus.FlushW = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
            4'($urandom_range(0, 15)));
      step("rand");
      if ($urandom_range(0, 199) == 0) begin
        @(negedge CLK);
        #1;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
